id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand forwarding; sits directly upstream of the ALU.
//  Captures decoded operands/control each cycle and drives ALU src1/src2/ctrl.
//  Resolves RAW hazards from the EX/MEM and MEM/WB stages. Supports stall (hold) and flush (bubble).
// PARAMETERS
//  DATA_W   32  operand / result width
//  REG_AW   5   register address width
//  CTRL_W   4   ALU control width; codes pass through unchanged
// PORTS
//  clk_i              in   1        clock, rising edge
//  rst_i              in   1        reset, asynchronous, active-high
//  stall_i            in   1        hold all pipeline registers this cycle
//  flush_i            in   1        load a bubble this cycle
//  valid_i            in   1        ID-stage instruction valid
//  rs_data_i          in   DATA_W   register-file read data, rs
//  rt_data_i          in   DATA_W   register-file read data, rt
//  imm_i              in   DATA_W   sign/zero-extended immediate
//  rs_addr_i          in   REG_AW   rs index
//  rt_addr_i          in   REG_AW   rt index
//  rd_addr_i          in   REG_AW   destination index, already muxed
//  alu_ctrl_i         in   CTRL_W   ALU operation
//  alu_src_i          in   1        1 = src2 is the immediate
//  reg_write_i        in   1        instruction writes rd
//  exmem_reg_write_i  in   1        EX/MEM instruction writes back
//  exmem_rd_i         in   REG_AW   EX/MEM destination
//  exmem_result_i     in   DATA_W   EX/MEM ALU result
//  memwb_reg_write_i  in   1        MEM/WB instruction writes back
//  memwb_rd_i         in   REG_AW   MEM/WB destination
//  memwb_data_i       in   DATA_W   MEM/WB write-back data
//  src1_o             out  DATA_W   ALU operand 1
//  src2_o             out  DATA_W   ALU operand 2
//  ctrl_o             out  CTRL_W   ALU control
//  store_data_o       out  DATA_W   forwarded rt, for stores
//  rd_addr_o          out  REG_AW   registered destination
//  reg_write_o        out  1        registered write enable, gated by valid
//  valid_o            out  1        stage holds a real instruction
//  fwd_a_o            out  2        src1 select: 00 reg, 01 MEM/WB, 10 EX/MEM
//  fwd_b_o            out  2        rt select, same encoding
// BEHAVIOUR
//  - Reset (async, any time, including mid-stall): all registers 0, so valid_o=0, reg_write_o=0 and ctrl_o=0.
//  - Rising-edge priority: rst_i > flush_i > stall_i > load.
//    - flush: valid=0, reg_write=0, ctrl=0, all data/address registers=0.
//    - stall: every register holds.
//    - load: every register captures its *_i input.
//  - Latency: 1 cycle from ID inputs to the registered fields. Forwarding muxes after the registers are purely combinational, 0 cycles.
//  - Forward A (applied likewise to B using rt_q):
//    - 10 if exmem_reg_write_i && exmem_rd_i!=0 && exmem_rd_i==rs_q.
//    - else 01 if memwb_reg_write_i && memwb_rd_i!=0 && memwb_rd_i==rs_q.
//    - else 00.
//    - EX/MEM always wins when both stages match.
//  - Register 0 is never forwarded; its operand is rs_data_q/rt_data_q as captured.
//  - When valid_q=0, fwd_a_o and fwd_b_o are forced to 00.
//  - Operand outputs:
//    - src1_o = forwarded rs.
//    - store_data_o = forwarded rt.
//    - src2_o = alu_src_q ? imm_q : forwarded rt.
//  - reg_write_o = reg_write_q & valid_q. ctrl_o and rd_addr_o are the raw registered values.
//  - Forwarding uses the live EX/MEM and MEM/WB inputs every cycle, including while stalled. A held instruction picks up newer data.
// TESTING
//  - Reset: assert rst_i between edges -> all outputs 0 immediately, with no clock edge needed.
//  - Load: rs=3, rs_data=5, rt_data=7, ctrl=0010, no hazards -> next cycle src1_o=5, src2_o=7, ctrl_o=0010, fwd_a_o=00.
//  - Double hazard: rs_q=4, exmem_rd=4 with result 0x11, memwb_rd=4 with data 0x22 -> src1_o=0x11, fwd_a_o=10.
//  - Register 0: rs_q=0, exmem_rd=0, exmem_reg_write=1, result 0x99 -> src1_o = captured rs_data, fwd_a_o=00.
//  - Immediate: alu_src_q=1, imm=0xFFFFFFF0, rt hazard from MEM/WB with 0x33 -> src2_o=0xFFFFFFF0, store_data_o=0x33, fwd_b_o=01.
//  - Stall then flush: stall 2 cycles (outputs hold), then assert flush_i and stall_i together -> valid_o=0, reg_write_o=0, ctrl_o=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from EX/MEM and MEM/WB.
// Feeds ALU src1/src2/ctrl and the forwarded store data; supports stall (hold) and flush (bubble).
module id_ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [CTRL_W-1:0] alu_ctrl_i,
    input  logic              alu_src_i,
    input  logic              reg_write_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] src1_o,
    output logic [DATA_W-1:0] src2_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_write_o,
    output logic              valid_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;

    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    always_comb begin
        d           = '0;
        d.valid     = valid_i;
        d.reg_write = reg_write_i;
        d.alu_src   = alu_src_i;
        d.ctrl      = alu_ctrl_i;
        d.rs_addr   = rs_addr_i;
        d.rt_addr   = rt_addr_i;
        d.rd_addr   = rd_addr_i;
        d.rs_data   = rs_data_i;
        d.rt_data   = rt_data_i;
        d.imm       = imm_i;
    end

    // Pipeline register: flush loads an all-zero bubble, stall holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (flush_i) begin
            q <= '0;
        end else if (!stall_i) begin
            q <= d;
        end
    end

    // Hazard detect on live downstream stages; EX/MEM is newer so it wins; r0 never forwards.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (q.valid) begin
            if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == q.rs_addr)) begin
                fwd_a = FWD_EXMEM;
            end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == q.rs_addr)) begin
                fwd_a = FWD_MEMWB;
            end
            if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == q.rt_addr)) begin
                fwd_b = FWD_EXMEM;
            end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == q.rt_addr)) begin
                fwd_b = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        case (fwd_a)
            FWD_EXMEM: rs_fwd = exmem_result_i;
            FWD_MEMWB: rs_fwd = memwb_data_i;
            default:   rs_fwd = q.rs_data;
        endcase
        case (fwd_b)
            FWD_EXMEM: rt_fwd = exmem_result_i;
            FWD_MEMWB: rt_fwd = memwb_data_i;
            default:   rt_fwd = q.rt_data;
        endcase
    end

    assign src1_o       = rs_fwd;
    assign src2_o       = q.alu_src ? q.imm : rt_fwd;
    assign store_data_o = rt_fwd;
    assign ctrl_o       = q.ctrl;
    assign rd_addr_o    = q.rd_addr;
    assign reg_write_o  = q.reg_write & q.valid;
    assign valid_o      = q.valid;
    assign fwd_a_o      = fwd_a;
    assign fwd_b_o      = fwd_b;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage: reset, load, forwarding priority,
// register-0 exclusion, immediate select, valid gating, stall/flush and back-to-back loads.
module tb_id_ex_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, valid_i;
    logic [31:0] rs_data_i, rt_data_i, imm_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
    logic [3:0]  alu_ctrl_i;
    logic        alu_src_i, reg_write_i;
    logic        exmem_reg_write_i;
    logic [4:0]  exmem_rd_i;
    logic [31:0] exmem_result_i;
    logic        memwb_reg_write_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_data_i;
    logic [31:0] src1_o, src2_o, store_data_o;
    logic [3:0]  ctrl_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, valid_o;
    logic [1:0]  fwd_a_o, fwd_b_o;

    int checks = 0;
    int errors = 0;

    id_ex_operand_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .alu_ctrl_i(alu_ctrl_i), .alu_src_i(alu_src_i), .reg_write_i(reg_write_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o), .store_data_o(store_data_o),
        .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .valid_o(valid_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                            input logic [3:0] ctrl, input logic asrc, input logic rw);
        valid_i = v; rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
        rs_data_i = rsd; rt_data_i = rtd; imm_i = imm;
        alu_ctrl_i = ctrl; alu_src_i = asrc; reg_write_i = rw;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mdat);
        exmem_reg_write_i = ew; exmem_rd_i = erd; exmem_result_i = eres;
        memwb_reg_write_i = mw; memwb_rd_i = mrd; memwb_data_i = mdat;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick(); tick();
        rst_i = 1'b0;
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 4'h7, 1'b0, 1'b1);
        tick();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rst_preload_valid: got %b expected 1", valid_o); end
        // Async reset mid-cycle while stalled, with a live hazard on the inputs.
        stall_i = 1'b1;
        set_fwd(1'b1, 5'd1, 32'hDEAD, 1'b1, 5'd2, 32'hBEEF);
        #2; rst_i = 1'b1; #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL rst_reg_write: got %b expected 0", reg_write_o); end
        checks++; if (ctrl_o !== 4'h0) begin errors++; $display("FAIL rst_ctrl: got %h expected 0", ctrl_o); end
        checks++; if (src1_o !== 32'h0) begin errors++; $display("FAIL rst_src1: got %h expected 0", src1_o); end
        checks++; if (src2_o !== 32'h0) begin errors++; $display("FAIL rst_src2: got %h expected 0", src2_o); end
        checks++; if (store_data_o !== 32'h0) begin errors++; $display("FAIL rst_store: got %h expected 0", store_data_o); end
        checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL rst_rd: got %h expected 0", rd_addr_o); end
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin errors++; $display("FAIL rst_fwd: got %b expected 0000", {fwd_a_o, fwd_b_o}); end
        #1; rst_i = 1'b0; stall_i = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_load();
        drive_id(1'b1, 5'd3, 5'd6, 5'd9, 32'h5, 32'h7, 32'h0, 4'b0010, 1'b0, 1'b1);
        #1;
        checks++; if (ctrl_o === 4'b0010) begin errors++; $display("FAIL load_latency: got %h expected not 2 before edge", ctrl_o); end
        tick();
        checks++; if (src1_o !== 32'h5) begin errors++; $display("FAIL load_src1: got %h expected 5", src1_o); end
        checks++; if (src2_o !== 32'h7) begin errors++; $display("FAIL load_src2: got %h expected 7", src2_o); end
        checks++; if (store_data_o !== 32'h7) begin errors++; $display("FAIL load_store: got %h expected 7", store_data_o); end
        checks++; if (ctrl_o !== 4'b0010) begin errors++; $display("FAIL load_ctrl: got %h expected 2", ctrl_o); end
        checks++; if (rd_addr_o !== 5'd9) begin errors++; $display("FAIL load_rd: got %0d expected 9", rd_addr_o); end
        checks++; if (reg_write_o !== 1'b1) begin errors++; $display("FAIL load_reg_write: got %b expected 1", reg_write_o); end
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin errors++; $display("FAIL load_fwd: got %b expected 0000", {fwd_a_o, fwd_b_o}); end
    endtask

    task automatic test_double_hazard();
        drive_id(1'b1, 5'd4, 5'd8, 5'd10, 32'h44, 32'h88, 32'h0, 4'h1, 1'b0, 1'b1);
        tick();
        set_fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        checks++; if (src1_o !== 32'h11) begin errors++; $display("FAIL dbl_src1: got %h expected 11", src1_o); end
        checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL dbl_fwd_a: got %b expected 10", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL dbl_fwd_b: got %b expected 00", fwd_b_o); end
        set_fwd(1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        checks++; if (src1_o !== 32'h22) begin errors++; $display("FAIL memwb_src1: got %h expected 22", src1_o); end
        checks++; if (fwd_a_o !== 2'b01) begin errors++; $display("FAIL memwb_fwd_a: got %b expected 01", fwd_a_o); end
        // EX/MEM writes a different register; MEM/WB still matches rs, EX/MEM matches rt.
        set_fwd(1'b1, 5'd8, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        checks++; if (src1_o !== 32'h22) begin errors++; $display("FAIL mixed_src1: got %h expected 22", src1_o); end
        checks++; if (src2_o !== 32'h11) begin errors++; $display("FAIL mixed_src2: got %h expected 11", src2_o); end
        checks++; if (fwd_b_o !== 2'b10) begin errors++; $display("FAIL mixed_fwd_b: got %b expected 10", fwd_b_o); end
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reg0();
        drive_id(1'b1, 5'd0, 5'd0, 5'd1, 32'hABC, 32'hDEF, 32'h0, 4'h3, 1'b0, 1'b1);
        tick();
        set_fwd(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77);
        #1;
        checks++; if (src1_o !== 32'hABC) begin errors++; $display("FAIL r0_src1: got %h expected abc", src1_o); end
        checks++; if (src2_o !== 32'hDEF) begin errors++; $display("FAIL r0_src2: got %h expected def", src2_o); end
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin errors++; $display("FAIL r0_fwd: got %b expected 0000", {fwd_a_o, fwd_b_o}); end
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_immediate();
        drive_id(1'b1, 5'd2, 5'd7, 5'd5, 32'h20, 32'h70, 32'hFFFF_FFF0, 4'h6, 1'b1, 1'b1);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h33);
        #1;
        checks++; if (src2_o !== 32'hFFFF_FFF0) begin errors++; $display("FAIL imm_src2: got %h expected fffffff0", src2_o); end
        checks++; if (store_data_o !== 32'h33) begin errors++; $display("FAIL imm_store: got %h expected 33", store_data_o); end
        checks++; if (fwd_b_o !== 2'b01) begin errors++; $display("FAIL imm_fwd_b: got %b expected 01", fwd_b_o); end
        checks++; if (src1_o !== 32'h20) begin errors++; $display("FAIL imm_src1: got %h expected 20", src1_o); end
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_valid_gate();
        drive_id(1'b0, 5'd4, 5'd4, 5'd6, 32'h123, 32'h456, 32'h0, 4'h9, 1'b0, 1'b1);
        tick();
        set_fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
        #1;
        checks++; if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin errors++; $display("FAIL inv_fwd: got %b expected 0000", {fwd_a_o, fwd_b_o}); end
        checks++; if (src1_o !== 32'h123) begin errors++; $display("FAIL inv_src1: got %h expected 123", src1_o); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL inv_reg_write: got %b expected 0", reg_write_o); end
        checks++; if (ctrl_o !== 4'h9) begin errors++; $display("FAIL inv_ctrl: got %h expected 9", ctrl_o); end
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_stall_flush();
        drive_id(1'b1, 5'd2, 5'd3, 5'd3, 32'h20, 32'h30, 32'h0, 4'b0101, 1'b0, 1'b1);
        tick();
        stall_i = 1'b1;
        drive_id(1'b1, 5'd9, 5'd9, 5'd9, 32'hFF, 32'hEE, 32'hDD, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (src1_o !== 32'h20) begin errors++; $display("FAIL stall_src1[%0d]: got %h expected 20", i, src1_o); end
            checks++; if (ctrl_o !== 4'b0101) begin errors++; $display("FAIL stall_ctrl[%0d]: got %h expected 5", i, ctrl_o); end
            checks++; if (rd_addr_o !== 5'd3) begin errors++; $display("FAIL stall_rd[%0d]: got %0d expected 3", i, rd_addr_o); end
            checks++; if (src2_o !== 32'h30) begin errors++; $display("FAIL stall_src2[%0d]: got %h expected 30", i, src2_o); end
        end
        set_fwd(1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 32'h0);
        #1;
        checks++; if (src1_o !== 32'h55) begin errors++; $display("FAIL stall_fwd_src1: got %h expected 55", src1_o); end
        checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL stall_fwd_a: got %b expected 10", fwd_a_o); end
        flush_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", valid_o); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL flush_reg_write: got %b expected 0", reg_write_o); end
        checks++; if (ctrl_o !== 4'h0) begin errors++; $display("FAIL flush_ctrl: got %h expected 0", ctrl_o); end
        checks++; if (src1_o !== 32'h0) begin errors++; $display("FAIL flush_src1: got %h expected 0", src1_o); end
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL flush_fwd_a: got %b expected 00", fwd_a_o); end
        flush_i = 1'b0; stall_i = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_back_to_back();
        drive_id(1'b1, 5'd11, 5'd12, 5'd13, 32'h1111, 32'h2222, 32'h0, 4'hA, 1'b0, 1'b1);
        tick();
        drive_id(1'b1, 5'd14, 5'd15, 5'd16, 32'h3333, 32'h4444, 32'h10, 4'hB, 1'b1, 1'b0);
        checks++; if (src1_o !== 32'h1111) begin errors++; $display("FAIL b2b0_src1: got %h expected 1111", src1_o); end
        checks++; if (rd_addr_o !== 5'd13) begin errors++; $display("FAIL b2b0_rd: got %0d expected 13", rd_addr_o); end
        tick();
        checks++; if (src1_o !== 32'h3333) begin errors++; $display("FAIL b2b1_src1: got %h expected 3333", src1_o); end
        checks++; if (src2_o !== 32'h10) begin errors++; $display("FAIL b2b1_src2: got %h expected 10", src2_o); end
        checks++; if (store_data_o !== 32'h4444) begin errors++; $display("FAIL b2b1_store: got %h expected 4444", store_data_o); end
        checks++; if (ctrl_o !== 4'hB) begin errors++; $display("FAIL b2b1_ctrl: got %h expected b", ctrl_o); end
        checks++; if (reg_write_o !== 1'b0) begin errors++; $display("FAIL b2b1_reg_write: got %b expected 0", reg_write_o); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_double_hazard();
        test_reg0();
        test_immediate();
        test_valid_gate();
        test_stall_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
